// File: rtl/adc_cfg_pkg.sv
// Shared definitions for the ADC configuration sequencer.
// State encodings and configuration-entry field layout.
package adc_cfg_pkg;

    localparam int ENTRY_W  = 36;
    localparam int DATA_LSB = 0;
    localparam int CPHA_BIT = 32;
    localparam int CPOL_BIT = 33;
    localparam int SEL_LSB  = 34;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_KICK    = 3'd2;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
    localparam logic [2:0] ST_WAIT_LO = 3'd4;
    localparam logic [2:0] ST_GAP     = 3'd5;
    localparam logic [2:0] ST_FIN     = 3'd6;
    localparam logic [2:0] ST_ERR     = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        LOAD    = ST_LOAD,
        KICK    = ST_KICK,
        WAIT_HI = ST_WAIT_HI,
        WAIT_LO = ST_WAIT_LO,
        GAP     = ST_GAP,
        FIN     = ST_FIN,
        ERR     = ST_ERR
    } state_t;

endpackage

// File: rtl/adc_cfg_table.sv
// Configuration word store: synchronous write, combinational read.
// Contents survive reset so a list can be replayed after an abort.
module adc_cfg_table
    import adc_cfg_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/adc_cfg_seq.sv
// Replays a table of ADC configuration words into SPI4ADC,
// one spi_start per entry, with ack/transfer timeouts.
module adc_cfg_seq
    import adc_cfg_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int GAP_CYC = 16,
    parameter int ACK_TO  = 64,
    parameter int XFER_TO = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [ENTRY_W-1:0] cfg_wdata,
    input  logic [AW:0]        cfg_len,
    input  logic               start,
    input  logic               spi_status,
    output logic               spi_start,
    output logic [31:0]        spi_data,
    output logic               spi_cpol,
    output logic               spi_cpha,
    output logic               ps_A0,
    output logic               ps_A1,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [AW-1:0]      cur_idx
);

    localparam int TW = $clog2(XFER_TO + 1);

    state_t             state;
    logic [TW-1:0]      tmr;
    logic [TW-1:0]      tmr_inc;
    logic [AW:0]        len_q;
    logic [AW:0]        idx_nxt;
    logic [ENTRY_W-1:0] entry;

    adc_cfg_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk   (clk),
        .we    (cfg_we & ~busy),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (cur_idx),
        .rdata (entry)
    );

    assign tmr_inc = (tmr == {TW{1'b1}}) ? tmr : tmr + 1'b1;
    assign idx_nxt = {1'b0, cur_idx} + {{AW{1'b0}}, 1'b1};

    // Timeouts are flagged on entry to ERR so err rises exactly
    // ACK_TO / XFER_TO cycles into the wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tmr       <= '0;
            len_q     <= '0;
            cur_idx   <= '0;
            spi_start <= 1'b0;
            spi_data  <= '0;
            spi_cpol  <= 1'b0;
            spi_cpha  <= 1'b0;
            ps_A0     <= 1'b0;
            ps_A1     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        cur_idx <= '0;
                        len_q   <= cfg_len;
                        state   <= (cfg_len == '0) ? FIN : LOAD;
                    end
                end
                LOAD: begin
                    spi_data <= entry[DATA_LSB +: 32];
                    spi_cpol <= entry[CPOL_BIT];
                    spi_cpha <= entry[CPHA_BIT];
                    ps_A0    <= entry[SEL_LSB];
                    ps_A1    <= entry[SEL_LSB + 1];
                    state    <= KICK;
                end
                KICK: begin
                    spi_start <= 1'b1;
                    tmr       <= '0;
                    state     <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (spi_status) begin
                        tmr   <= '0;
                        state <= WAIT_LO;
                    end else if (tmr_inc == TW'(ACK_TO)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERR;
                    end else begin
                        tmr <= tmr_inc;
                    end
                end
                WAIT_LO: begin
                    if (!spi_status) begin
                        tmr   <= '0;
                        state <= GAP;
                    end else if (tmr_inc == TW'(XFER_TO)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERR;
                    end else begin
                        tmr <= tmr_inc;
                    end
                end
                GAP: begin
                    if (tmr_inc == TW'(GAP_CYC)) begin
                        tmr <= '0;
                        if (idx_nxt == len_q) begin
                            state <= FIN;
                        end else begin
                            cur_idx <= idx_nxt[AW-1:0];
                            state   <= LOAD;
                        end
                    end else begin
                        tmr <= tmr_inc;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_cfg_seq.sv
// Directed bench for adc_cfg_seq with a behavioural SPI4ADC status model.
// Mode 0: status high 1600 cycles per kick; 1: never; 2: stuck high.
module tb_adc_cfg_seq;

    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int GAP_CYC = 16;
    localparam int ACK_TO  = 64;
    localparam int XFER_TO = 4096;
    localparam int HI_CYC  = 1600;

    localparam logic [35:0] E0 = {2'b10, 1'b1, 1'b1, 32'hF800_0001};
    localparam logic [35:0] E1 = {2'b01, 1'b1, 1'b0, 32'hF400_00FF};
    localparam logic [35:0] E2 = {2'b11, 1'b0, 1'b1, 32'hA5A5_0042};
    localparam logic [35:0] EX = {2'b00, 1'b0, 1'b0, 32'h1234_5678};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [35:0]   cfg_wdata = '0;
    logic [AW:0]   cfg_len = '0;
    logic          start = 1'b0;
    logic          spi_status = 1'b0;
    logic          spi_start;
    logic [31:0]   spi_data;
    logic          spi_cpol;
    logic          spi_cpha;
    logic          ps_A0;
    logic          ps_A1;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] cur_idx;

    always #10 clk = ~clk;

    adc_cfg_seq #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .GAP_CYC (GAP_CYC),
        .ACK_TO  (ACK_TO),
        .XFER_TO (XFER_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_len    (cfg_len),
        .start      (start),
        .spi_status (spi_status),
        .spi_start  (spi_start),
        .spi_data   (spi_data),
        .spi_cpol   (spi_cpol),
        .spi_cpha   (spi_cpha),
        .ps_A0      (ps_A0),
        .ps_A1      (ps_A1),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cur_idx    (cur_idx)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;
    int hi_left = 0;
    int kicks = 0;
    int dones = 0;
    int          k_cyc [$];
    logic [31:0] k_data[$];
    logic [1:0]  k_sel [$];
    logic [1:0]  k_cp  [$];
    logic [AW-1:0] k_idx[$];
    int          fall_seen[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (spi_start) begin
            kicks++;
            k_cyc.push_back(cyc);
            k_data.push_back(spi_data);
            k_sel.push_back({ps_A1, ps_A0});
            k_cp.push_back({spi_cpol, spi_cpha});
            k_idx.push_back(cur_idx);
            if (mode == 0) hi_left = HI_CYC;
        end
        if (done) dones++;
        if (rst) hi_left = 0;
        if (mode == 1) begin
            spi_status = 1'b0;
        end else if (mode == 2) begin
            spi_status = 1'b1;
        end else if (hi_left > 0) begin
            spi_status = 1'b1;
            hi_left--;
        end else begin
            if (spi_status) fall_seen.push_back(cyc + 1);
            spi_status = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [35:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic go(input logic [AW:0] len);
        cfg_len = len;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            tick(1);
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_kick(input string tag, input int kb, input int max);
        int n = 0;
        while (kicks == kb && n < max) begin
            tick(1);
            n++;
        end
        check(tag, kicks - kb, 1);
    endtask

    task automatic wait_err(input string tag, input int max,
                            output int at);
        int n = 0;
        while (!err && n < max) begin
            tick(1);
            n++;
        end
        at = cyc;
        check(tag, err, 1);
    endtask

    initial begin
        int kb;
        int db;
        int fb;
        int c0;
        int kc;
        int ec;

        tick(3);
        check("rst_outs",
              {spi_start, busy, done, err, ps_A0, ps_A1,
               spi_cpol, spi_cpha, cur_idx, spi_data}, 0);
        rst = 1'b0;
        tick(2);

        // two entries back to back
        wr(3'd0, E0);
        wr(3'd1, E1);
        kb = kicks;
        db = dones;
        fb = fall_seen.size();
        c0 = cyc;
        go(4'd2);
        wait_idle("run2_idle", 5000);
        check("run2_kicks", kicks - kb, 2);
        check("run2_lat", k_cyc[kb] - c0, 3);
        check("run2_d0", k_data[kb], 32'hF800_0001);
        check("run2_sel0", k_sel[kb], 2'b10);
        check("run2_cp0", k_cp[kb], 2'b11);
        check("run2_d1", k_data[kb+1], 32'hF400_00FF);
        check("run2_sel1", k_sel[kb+1], 2'b01);
        check("run2_cp1", k_cp[kb+1], 2'b10);
        check("run2_idx1", k_idx[kb+1], 1);
        check("run2_gap", k_cyc[kb+1] - fall_seen[fb], GAP_CYC + 2);
        check("run2_done", dones - db, 1);
        check("run2_err", err, 0);
        tick(2);

        // empty list
        kb = kicks;
        cfg_len = '0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("len0_busy", {busy, done}, 2'b10);
        tick(1);
        check("len0_done", {busy, done}, 2'b01);
        tick(1);
        check("len0_end", {busy, done}, 2'b00);
        tick(3);
        check("len0_nokick", kicks - kb, 0);

        // status never rises
        mode = 1;
        kb = kicks;
        db = dones;
        go(4'd1);
        wait_kick("ack_kick", kb, 20);
        kc = k_cyc[k_cyc.size()-1];
        wait_err("ack_err", 200, ec);
        check("ack_time", ec - kc, ACK_TO);
        check("ack_busy", busy, 0);
        check("ack_nodone", dones - db, 0);
        tick(2);
        go(4'd1);
        check("ack_clr", err, 0);
        wait_idle("ack2_idle", 200);
        check("ack2_err", err, 1);
        tick(2);

        // status stuck high
        mode = 2;
        tick(3);
        check("idle_hi_ok", {busy, err}, 2'b01);
        kb = kicks;
        go(4'd1);
        wait_kick("xfer_kick", kb, 20);
        kc = k_cyc[k_cyc.size()-1];
        wait_err("xfer_err", 5000, ec);
        check("xfer_time", ec - kc, XFER_TO + 1);
        check("xfer_busy", busy, 0);
        mode = 0;
        tick(4);

        // write and start while busy are ignored
        kb = kicks;
        db = dones;
        go(4'd1);
        tick(100);
        wr(3'd0, EX);
        go(4'd3);
        wait_idle("bw_idle", 3000);
        check("bw_kicks", kicks - kb, 1);
        check("bw_done", dones - db, 1);
        tick(2);
        kb = kicks;
        go(4'd1);
        wait_idle("bw2_idle", 3000);
        check("bw2_data", k_data[kb], 32'hF800_0001);
        check("bw2_sel", k_sel[kb], 2'b10);
        tick(2);

        // reset in the middle of a transfer
        kb = kicks;
        go(4'd2);
        wait_kick("rs_kick", kb, 20);
        tick(50);
        #3;
        rst = 1'b1;
        #1;
        check("rs_outs",
              {spi_start, busy, done, err, ps_A0, ps_A1,
               spi_cpol, spi_cpha, cur_idx, spi_data}, 0);
        tick(2);
        rst = 1'b0;
        tick(3);
        kb = kicks;
        go(4'd2);
        wait_kick("rs2_kick", kb, 20);
        check("rs2_idx", k_idx[kb], 0);
        check("rs2_data", k_data[kb], 32'hF800_0001);
        wait_idle("rs2_idle", 5000);
        check("rs2_kicks", kicks - kb, 2);
        tick(2);

        // write and start in the same idle cycle
        kb = kicks;
        cfg_we = 1'b1;
        cfg_addr = 3'd0;
        cfg_wdata = E2;
        cfg_len = 4'd1;
        start = 1'b1;
        tick(1);
        cfg_we = 1'b0;
        start = 1'b0;
        wait_idle("ws_idle", 3000);
        check("ws_data", k_data[kb], 32'hA5A5_0042);
        check("ws_sel", k_sel[kb], 2'b11);
        check("ws_cp", k_cp[kb], 2'b01);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
